// File: rtl/mem_stage.sv
// MIPS memory-access stage: word-addressed data memory, branch resolution,
// MEM/WB pipeline register and a debug read / clear-sweep port.
module mem_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_PC   = 6,
  parameter int unsigned NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic               i_MEM_branch,
  input  logic               i_MEM_zero,
  input  logic [NB_PC-1:0]   i_MEM_branch_address,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_write_data,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic               i_clear_req,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_MEM_pc_src,
  output logic [NB_PC-1:0]   o_MEM_branch_address,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic [NB_DATA-1:0] o_WB_read_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_busy,
  output logic               o_clear_done
);

  localparam int unsigned DEPTH = 1 << NB_ADDR;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t               state, state_next;
  logic [NB_ADDR-1:0]   counter, counter_next;
  logic [NB_DATA-1:0]   mem [DEPTH];
  logic [NB_ADDR-1:0]   index;
  logic [NB_ADDR-1:0]   wr_addr;
  logic [NB_DATA-1:0]   wr_data;
  logic                 wr_en;
  logic                 unused_addr_bits;

  // Byte address to word index; byte offset and high bits alias onto the same word
  assign index            = i_MEM_alu_result[NB_ADDR+1:2];
  assign unused_addr_bits = ^{i_MEM_alu_result[NB_DATA-1:NB_ADDR+2], i_MEM_alu_result[1:0]};

  assign o_MEM_pc_src         = i_MEM_branch & i_MEM_zero & ~o_busy;
  assign o_MEM_branch_address = i_MEM_branch_address;

  // Sweep state register; busy/done are registered decodes of the next state
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      counter      <= '0;
      o_busy       <= 1'b0;
      o_clear_done <= 1'b0;
    end else begin
      state        <= state_next;
      counter      <= counter_next;
      o_busy       <= (state_next != IDLE);
      o_clear_done <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    wr_en        = 1'b0;
    wr_addr      = index;
    wr_data      = i_MEM_write_data;
    case (state)
      IDLE: begin
        wr_en = i_enable & i_MEM_mem_write;
        if (i_clear_req) begin
          state_next   = CLEAR;
          counter_next = '0;
        end
      end
      CLEAR: begin
        wr_en        = 1'b1;
        wr_addr      = counter;
        wr_data      = '0;
        counter_next = counter + NB_ADDR'(1);
        if (counter == NB_ADDR'(DEPTH - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data memory contents are never reset
  always_ff @(posedge i_clock) begin
    if (wr_en && !i_reset) mem[wr_addr] <= wr_data;
  end

  // MEM/WB register loads a bubble while the clear sweep owns the memory
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_WB_reg_write    <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_read_data    <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_debug_data      <= '0;
    end else begin
      o_debug_data <= mem[i_debug_addr];
      if (i_enable) begin
        if (state == IDLE) begin
          o_WB_reg_write    <= i_MEM_reg_write;
          o_WB_mem_to_reg   <= i_MEM_mem_to_reg;
          o_WB_read_data    <= i_MEM_mem_read ? mem[index] : '0;
          o_WB_alu_result   <= i_MEM_alu_result;
          o_WB_selected_reg <= i_MEM_selected_reg;
        end else begin
          o_WB_reg_write    <= 1'b0;
          o_WB_mem_to_reg   <= 1'b0;
          o_WB_read_data    <= '0;
          o_WB_alu_result   <= '0;
          o_WB_selected_reg <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized and directed traffic checked
// against a behavioural memory/sweep model.
module tb_mem_stage;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_REG  = 5;
  localparam int unsigned NB_PC   = 6;
  localparam int unsigned NB_ADDR = 5;
  localparam int unsigned DEPTH   = 1 << NB_ADDR;
  localparam int          SWEEP   = DEPTH + 1;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               i_enable;
  logic               i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_mem_read, i_MEM_mem_write;
  logic               i_MEM_branch, i_MEM_zero;
  logic [NB_PC-1:0]   i_MEM_branch_address;
  logic [NB_DATA-1:0] i_MEM_alu_result, i_MEM_write_data;
  logic [NB_REG-1:0]  i_MEM_selected_reg;
  logic               i_clear_req;
  logic [NB_ADDR-1:0] i_debug_addr;
  logic               o_MEM_pc_src;
  logic [NB_PC-1:0]   o_MEM_branch_address;
  logic               o_WB_reg_write, o_WB_mem_to_reg;
  logic [NB_DATA-1:0] o_WB_read_data, o_WB_alu_result, o_debug_data;
  logic [NB_REG-1:0]  o_WB_selected_reg;
  logic               o_busy, o_clear_done;

  always #5 i_clock = ~i_clock;

  mem_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_PC(NB_PC), .NB_ADDR(NB_ADDR)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_MEM_reg_write(i_MEM_reg_write), .i_MEM_mem_to_reg(i_MEM_mem_to_reg),
    .i_MEM_mem_read(i_MEM_mem_read), .i_MEM_mem_write(i_MEM_mem_write),
    .i_MEM_branch(i_MEM_branch), .i_MEM_zero(i_MEM_zero),
    .i_MEM_branch_address(i_MEM_branch_address), .i_MEM_alu_result(i_MEM_alu_result),
    .i_MEM_write_data(i_MEM_write_data), .i_MEM_selected_reg(i_MEM_selected_reg),
    .i_clear_req(i_clear_req), .i_debug_addr(i_debug_addr),
    .o_MEM_pc_src(o_MEM_pc_src), .o_MEM_branch_address(o_MEM_branch_address),
    .o_WB_reg_write(o_WB_reg_write), .o_WB_mem_to_reg(o_WB_mem_to_reg),
    .o_WB_read_data(o_WB_read_data), .o_WB_alu_result(o_WB_alu_result),
    .o_WB_selected_reg(o_WB_selected_reg), .o_debug_data(o_debug_data),
    .o_busy(o_busy), .o_clear_done(o_clear_done)
  );

  // Reference model: memory image plus a count of remaining busy cycles
  logic [NB_DATA-1:0] mem_m [DEPTH];
  bit                 known_m [DEPTH];
  logic               wb_reg_write_m, wb_mem_to_reg_m;
  logic [NB_DATA-1:0] wb_rd_m, wb_alu_m, dbg_m;
  logic [NB_REG-1:0]  wb_sel_m;
  bit                 wb_rd_known, dbg_known;
  int                 sweep_left, clear_idx;
  int                 n_vec, n_bad, done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wb_reg_write_m = 1'b0; wb_mem_to_reg_m = 1'b0;
    wb_rd_m = '0; wb_alu_m = '0; wb_sel_m = '0; dbg_m = '0;
    wb_rd_known = 1'b1; dbg_known = 1'b1;
    sweep_left = 0; clear_idx = 0;
  endtask

  task automatic check_outputs();
    check("pc_src", 32'(o_MEM_pc_src), 32'(i_MEM_branch & i_MEM_zero & (sweep_left == 0)));
    check("br_addr", 32'(o_MEM_branch_address), 32'(i_MEM_branch_address));
    check("busy", 32'(o_busy), 32'(sweep_left > 0));
    check("clear_done", 32'(o_clear_done), 32'(sweep_left == 1));
    check("wb_reg_write", 32'(o_WB_reg_write), 32'(wb_reg_write_m));
    check("wb_mem_to_reg", 32'(o_WB_mem_to_reg), 32'(wb_mem_to_reg_m));
    check("wb_alu", o_WB_alu_result, wb_alu_m);
    check("wb_sel", 32'(o_WB_selected_reg), 32'(wb_sel_m));
    if (wb_rd_known) check("wb_read_data", o_WB_read_data, wb_rd_m);
    if (dbg_known) check("debug_data", o_debug_data, dbg_m);
  endtask

  // One clock edge of the architectural behaviour, using the inputs held across it
  task automatic model_edge();
    logic [NB_ADDR-1:0] idx;
    idx       = i_MEM_alu_result[NB_ADDR+1:2];
    dbg_m     = mem_m[i_debug_addr];
    dbg_known = known_m[i_debug_addr];
    if (sweep_left == 0) begin
      if (i_enable) begin
        wb_reg_write_m  = i_MEM_reg_write;
        wb_mem_to_reg_m = i_MEM_mem_to_reg;
        wb_alu_m        = i_MEM_alu_result;
        wb_sel_m        = i_MEM_selected_reg;
        wb_rd_m         = i_MEM_mem_read ? mem_m[idx] : '0;
        wb_rd_known     = i_MEM_mem_read ? known_m[idx] : 1'b1;
        if (i_MEM_mem_write) begin
          mem_m[idx]   = i_MEM_write_data;
          known_m[idx] = 1'b1;
        end
      end
      if (i_clear_req) begin
        sweep_left = SWEEP;
        clear_idx  = 0;
      end
    end else begin
      if (i_enable) begin
        wb_reg_write_m = 1'b0; wb_mem_to_reg_m = 1'b0;
        wb_rd_m = '0; wb_alu_m = '0; wb_sel_m = '0; wb_rd_known = 1'b1;
      end
      if (clear_idx < int'(DEPTH)) begin
        mem_m[clear_idx]   = '0;
        known_m[clear_idx] = 1'b1;
        clear_idx++;
      end
      sweep_left--;
    end
  endtask

  // Inputs are set at the falling edge; check shortly after, then advance
  task automatic step();
    #1;
    check_outputs();
    if (o_clear_done) done_seen++;
    @(posedge i_clock);
    if (!i_reset) model_edge();
    @(negedge i_clock);
  endtask

  task automatic quiet_inputs();
    i_enable = 1'b1;
    i_MEM_reg_write = 1'b0; i_MEM_mem_to_reg = 1'b0;
    i_MEM_mem_read = 1'b0; i_MEM_mem_write = 1'b0;
    i_MEM_branch = 1'b0; i_MEM_zero = 1'b0; i_MEM_branch_address = '0;
    i_MEM_alu_result = '0; i_MEM_write_data = '0; i_MEM_selected_reg = '0;
    i_clear_req = 1'b0; i_debug_addr = '0;
  endtask

  task automatic rand_inputs(input bit allow_clear);
    i_enable             = ($urandom_range(0, 9) != 0);
    i_MEM_reg_write      = 1'($urandom);
    i_MEM_mem_to_reg     = 1'($urandom);
    i_MEM_mem_read       = 1'($urandom);
    i_MEM_mem_write      = ($urandom_range(0, 2) == 0);
    i_MEM_branch         = 1'($urandom);
    i_MEM_zero           = 1'($urandom);
    i_MEM_branch_address = NB_PC'($urandom);
    i_MEM_alu_result     = $urandom;
    i_MEM_write_data     = $urandom;
    i_MEM_selected_reg   = NB_REG'($urandom);
    i_clear_req          = allow_clear && ($urandom_range(0, 59) == 0);
    i_debug_addr         = NB_ADDR'($urandom);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    quiet_inputs();
    i_MEM_mem_write = 1'b1; i_MEM_alu_result = addr; i_MEM_write_data = data;
    step();
  endtask

  task automatic load(input logic [31:0] addr);
    quiet_inputs();
    i_MEM_mem_read = 1'b1; i_MEM_mem_to_reg = 1'b1; i_MEM_reg_write = 1'b1;
    i_MEM_alu_result = addr; i_MEM_selected_reg = 5'd9;
    step();
  endtask

  task automatic fill_memory();
    for (int i = 0; i < int'(DEPTH); i++) store(32'(i * 4), $urandom | 32'h1);
  endtask

  task automatic debug_sweep();
    for (int i = 0; i <= int'(DEPTH); i++) begin
      quiet_inputs();
      i_enable = 1'b0;
      i_debug_addr = NB_ADDR'(i);
      step();
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; done_seen = 0;
    for (int i = 0; i < int'(DEPTH); i++) known_m[i] = 1'b0;
    quiet_inputs();
    i_reset = 1'b1;
    model_reset();
    @(negedge i_clock);
    step();
    i_reset = 1'b0;

    fill_memory();

    // Store then load, read data visible one cycle after the load
    store(32'h14, 32'hDEADBEEF);
    load(32'h14);
    quiet_inputs(); step();
    // Byte offset and high address bits alias onto the same word
    store(32'h15, 32'h11);
    load(32'h14);
    load(32'h94);
    // Simultaneous read and write returns the old word
    quiet_inputs();
    i_MEM_mem_read = 1'b1; i_MEM_mem_write = 1'b1;
    i_MEM_alu_result = 32'h20; i_MEM_write_data = 32'hCAFE0001;
    step();
    load(32'h20);

    // Branch resolution
    quiet_inputs(); i_MEM_branch = 1'b1; i_MEM_zero = 1'b1; i_MEM_branch_address = 6'h2A; step();
    i_MEM_zero = 1'b0; step();

    // Stalled store is dropped and WB holds
    load(32'h14);
    quiet_inputs();
    i_enable = 1'b0; i_MEM_mem_write = 1'b1; i_MEM_alu_result = 32'h0C;
    i_MEM_write_data = 32'h55; i_MEM_reg_write = 1'b0; i_debug_addr = 5'd3;
    step(); step();

    // Full clear sweep with a store and branch attempted mid-sweep
    fill_memory();
    quiet_inputs(); i_clear_req = 1'b1; done_seen = 0; step();
    for (int c = 0; c < SWEEP + 2; c++) begin
      quiet_inputs();
      i_MEM_branch = 1'b1; i_MEM_zero = 1'b1;
      if (c == 12) begin
        i_MEM_mem_write = 1'b1; i_MEM_alu_result = 32'h8; i_MEM_write_data = 32'hBAD0BAD0;
      end
      i_debug_addr = NB_ADDR'($urandom);
      step();
    end
    check("done_pulses", 32'(done_seen), 32'd1);
    debug_sweep();

    // Reset part way through a sweep
    fill_memory();
    quiet_inputs(); i_clear_req = 1'b1; done_seen = 0; step();
    quiet_inputs();
    for (int c = 0; c < SWEEP && clear_idx != 10; c++) step();
    check("sweep_reached_10", 32'(clear_idx), 32'd10);
    i_reset = 1'b1;
    model_reset();
    step(); step();
    i_reset = 1'b0;
    for (int c = 0; c < SWEEP + 2; c++) begin quiet_inputs(); step(); end
    check("done_after_reset", 32'(done_seen), 32'd0);
    debug_sweep();

    // Randomized traffic including occasional clear requests
    for (int c = 0; c < 2000; c++) begin
      rand_inputs(1'b1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS memory-access stage, directly downstream of the execute stage.
- Consumes the execute stage's control bits, ALU result, store data, branch target, zero flag and destination register.
- Holds the word-addressed data memory and resolves the branch decision.
- Owns the MEM/WB pipeline register and a debug read/clear port for the debug unit.

Parameters:
NB_DATA, 32, data/word width
NB_REG, 5, register index width
NB_PC, 6, PC/branch address width
NB_ADDR, 5, data memory word-address width (2^NB_ADDR words)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  pipeline advance; 0 = hold state, suppress writes
i_MEM_reg_write  in  1  register-file write control, forwarded to WB
i_MEM_mem_to_reg  in  1  WB source select, forwarded to WB
i_MEM_mem_read  in  1  load
i_MEM_mem_write  in  1  store
i_MEM_branch  in  1  branch instruction
i_MEM_zero  in  1  ALU zero flag
i_MEM_branch_address  in  NB_PC  branch target
i_MEM_alu_result  in  NB_DATA  byte address or ALU result
i_MEM_write_data  in  NB_DATA  store data
i_MEM_selected_reg  in  NB_REG  destination register
i_clear_req  in  1  one-cycle pulse: zero entire data memory
i_debug_addr  in  NB_ADDR  debug word address
o_MEM_pc_src  out  1  take branch
o_MEM_branch_address  out  NB_PC  branch target to fetch stage
o_WB_reg_write  out  1  registered
o_WB_mem_to_reg  out  1  registered
o_WB_read_data  out  NB_DATA  registered load data
o_WB_alu_result  out  NB_DATA  registered
o_WB_selected_reg  out  NB_REG  registered
o_debug_data  out  NB_DATA  registered mem[i_debug_addr]
o_busy  out  1  clear sweep in progress
o_clear_done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Memory: NB_DATA x 2^NB_ADDR words, no reset of contents.
  - Word index = i_MEM_alu_result[NB_ADDR+1:2]; bits [1:0] and bits above NB_ADDR+1 are ignored.
- Branch decision (combinational):
  - o_MEM_pc_src = i_MEM_branch & i_MEM_zero & ~o_busy.
  - o_MEM_branch_address = i_MEM_branch_address, passed through.
- Store: on a rising edge when i_enable & i_MEM_mem_write & state IDLE, mem[index] <= i_MEM_write_data.
- MEM/WB register, on a rising edge when i_enable and state IDLE:
  - Control bits, alu_result and selected_reg are captured.
  - o_WB_read_data <= mem[index] (old contents, read-before-write) if i_MEM_mem_read, else 0.
- i_enable=0: all MEM/WB outputs hold; no memory write.
- Busy cycle: while state != IDLE with i_enable=1, MEM/WB loads a bubble (all outputs 0).
- Load latency: one cycle; data appears on o_WB_read_data the cycle after the load is presented.
- Simultaneous i_MEM_mem_read & i_MEM_mem_write: write occurs; read returns pre-write value.
- Debug port: o_debug_data <= mem[i_debug_addr] every edge, independent of i_enable; one-cycle latency.
- FSM states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on i_clear_req (i_enable not required); counter <= 0.
  - CLEAR: mem[counter] <= 0 and counter++ each edge; on counter = 2^NB_ADDR-1, write it, then -> DONE.
  - DONE: o_clear_done = 1 for exactly one cycle, then -> IDLE.
  - o_busy = 1 in CLEAR and DONE. A sweep takes 2^NB_ADDR cycles in CLEAR plus 1 cycle in DONE.
  - i_clear_req outside IDLE is ignored. Pipeline stores are dropped while busy.
- Reset (asynchronous) sets:
  - All MEM/WB outputs and o_debug_data to 0.
  - State IDLE, counter 0, o_busy=0, o_clear_done=0.
- Reset mid-CLEAR aborts the sweep: already-cleared words stay 0, the rest keep their contents, and no o_clear_done pulse is produced.

Test Plan:
- Store/load: store 0xDEADBEEF at alu_result 0x14 (idx 5); next cycle load 0x14 -> o_WB_read_data=0xDEADBEEF one cycle later; o_WB_mem_to_reg follows the input.
- Aliasing: store 0x11 at 0x15, then load 0x14 -> 0x11 (low bits ignored); load 0x94 with NB_ADDR=5 -> same word 5.
- Branch: branch=1, zero=1, target 0x2A -> o_MEM_pc_src=1, o_MEM_branch_address=0x2A same cycle; zero=0 -> pc_src=0; during clear sweep -> pc_src=0.
- Stall: i_enable=0 with mem_write=1 data 0x55 idx 3 -> mem[3] unchanged (debug read), WB outputs hold prior values.
- Clear: fill words with nonzero data, pulse i_clear_req -> o_busy=1 for 33 cycles, o_clear_done pulses once, every debug read returns 0; store issued mid-sweep is dropped.
- Reset mid-sweep: assert i_reset at counter=10 -> outputs 0 immediately, state IDLE, words 0-9 read 0, words 11-31 keep old data (word 10 = old or 0), no done pulse.
